// File: rtl/rr_arbiter_timeout_if.sv
// Request/grant bundle between requester agents and the round-robin arbiter.
//   req     : per-requester request, level-sensitive (driven by requesters)
//   gnt     : registered one-hot grant (driven by arbiter)
//   gnt_id  : binary index of the current or most recent owner
//   busy    : high exactly while gnt is non-zero
//   timeout : one-cycle pulse after an owner is preempted by the tenure limit
// Handshake: a requester holds req high for as long as it needs the resource.
// It owns the resource in every cycle in which its gnt bit is high. It gives
// the resource up by dropping req. The grant always falls on the edge after
// req is seen low. A preempted owner sees its gnt bit fall while req is still
// high.
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_timeout_if #(
  parameter int N = 4
);
  logic [N-1:0]         req;
  logic [N-1:0]         gnt;
  logic [$clog2(N)-1:0] gnt_id;
  logic                 busy;
  logic                 timeout;

  modport master (output req, input gnt, input gnt_id, input busy, input timeout);
  modport slave  (input req, output gnt, output gnt_id, output busy, output timeout);
endinterface

// File: rtl/rr_arbiter_timeout.sv
// Round-robin arbiter with hold-until-release grants and tenure-limit preemption.
// An owner that has held the resource for MAX_HOLD cycles loses it on the first
// edge where another requester is waiting. Every grant is followed by one
// turnaround cycle with gnt low.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   resetn    : asynchronous active-low reset
//   bus       : request/grant bundle (slave side), see rr_arbiter_timeout_if
//   dbg_state : current FSM state (0 IDLE, 1 GRANT, 2 GAP), for observation
module rr_arbiter_timeout #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  rr_arbiter_timeout_if.slave    bus,
  output logic [1:0]             dbg_state
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

  state_t        state, state_n;
  logic [N-1:0]  gnt, gnt_n;
  logic [IW-1:0] gnt_id, gnt_id_n;
  logic          busy, busy_n;
  logic          timeout, timeout_n;
  logic [CW-1:0] hold_cnt, hold_cnt_n;
  logic [IW-1:0] ptr, ptr_n;

  logic [IW-1:0] winner;
  logic          any_req;
  logic          own_req;
  logic          other_req;

  // Search from the slot after the last winner. The last winner is checked
  // last, so a preempted owner that keeps requesting ranks behind everyone.
  always_comb begin
    logic found;
    found  = 1'b0;
    winner = ptr;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  assign any_req   = |bus.req;
  assign own_req   = bus.req[gnt_id];
  assign other_req = |(bus.req & ~gnt);

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    gnt_id_n   = gnt_id;
    busy_n     = busy;
    timeout_n  = 1'b0;
    hold_cnt_n = hold_cnt;
    ptr_n      = ptr;
    case (state)
      IDLE, GAP: begin
        if (any_req) begin
          gnt_n      = N'(1) << winner;
          gnt_id_n   = winner;
          ptr_n      = winner;
          hold_cnt_n = CW'(1);
          busy_n     = 1'b1;
          state_n    = GRANT;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        // Release is checked first, so an owner that drops req on the edge it
        // would have been preempted leaves without a timeout pulse.
        if (!own_req) begin
          gnt_n   = '0;
          busy_n  = 1'b0;
          state_n = GAP;
        end else if (hold_cnt == CW'(MAX_HOLD) && other_req) begin
          gnt_n     = '0;
          busy_n    = 1'b0;
          timeout_n = 1'b1;
          state_n   = GAP;
        end else if (hold_cnt != CW'(MAX_HOLD)) begin
          hold_cnt_n = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= IW'(N - 1);
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
      hold_cnt <= hold_cnt_n;
      ptr      <= ptr_n;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.gnt_id  = gnt_id;
  assign bus.busy    = busy;
  assign bus.timeout = timeout;
  assign dbg_state   = state;
endmodule

// File: tb/tb_rr_arbiter_timeout.sv
// Directed bench for rr_arbiter_timeout with N=4, MAX_HOLD=4.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point. Each step() therefore shows the effect of one edge on
// the inputs set before it.
module tb_rr_arbiter_timeout;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic       clk;
  logic       resetn;
  logic [1:0] dbg_state;

  rr_arbiter_timeout_if #(.N(N)) bus ();

  rr_arbiter_timeout #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard for the fairness grant order
  logic [1:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic b, input logic t);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, ".gnt_id"}, 32'(bus.gnt_id), 32'(id));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    logic [1:0] o;
    logic [3:0] r;
    resetn  = 1'b0;
    bus.req = 4'b0000;

    // 1. reset holds outputs low while req toggles
    for (int i = 0; i < 4; i++) begin
      bus.req = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      step();
      chk_out("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
      chk("reset_hold.state", 32'(dbg_state), 32'(S_IDLE));
    end
    bus.req = 4'b1111;
    resetn  = 1'b1;
    step();
    chk_out("reset_release", 4'b0001, 2'd0, 1'b1, 1'b0);
    chk("reset_release.state", 32'(dbg_state), 32'(S_GRANT));
    bus.req = 4'b0000;
    step();
    chk_out("reset_rel_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("reset_rel_drop.state", 32'(dbg_state), 32'(S_GAP));
    step();
    chk("reset_rel_idle.state", 32'(dbg_state), 32'(S_IDLE));

    // 2. single request on requester 2, held for 3 cycles
    bus.req = 4'b0100;
    step();
    chk_out("single_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
    step();
    chk_out("single_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
    step();
    chk_out("single_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step();
    chk_out("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    chk("single_rel.state", 32'(dbg_state), 32'(S_GAP));
    step();
    chk_out("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    chk("single_idle.state", 32'(dbg_state), 32'(S_IDLE));

    // 3. fairness: all requesting, each owner drops 2 cycles after grant
    do_reset();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      o = exp_q.pop_front();
      step();
      chk("fair.gnt", 32'(bus.gnt), 32'(4'b0001 << o));
      chk("fair.gnt_id", 32'(bus.gnt_id), 32'(o));
      step();
      chk("fair.hold", 32'(bus.gnt), 32'(4'b0001 << o));
      r = bus.req;
      r[o] = 1'b0;
      bus.req = r;
      step();
      chk("fair.gap", 32'(bus.gnt), 32'(0));
      chk("fair.gap_to", 32'(bus.timeout), 32'(0));
      r[o] = 1'b1;
      bus.req = r;
    end
    chk("fair.queue_empty", 32'(exp_q.size()), 32'(0));
    bus.req = 4'b0000;
    step();
    chk("fair.idle", 32'(dbg_state), 32'(S_IDLE));

    // 4. preemption of requester 0 by requester 1 (ptr is 0 here)
    bus.req = 4'b0001;
    step();
    chk_out("pre_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
    step();
    chk_out("pre_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.req = 4'b0011;
    step();
    chk_out("pre_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
    step();
    chk_out("pre_c4", 4'b0001, 2'd0, 1'b1, 1'b0);
    step();
    chk_out("pre_gap", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    chk_out("pre_new", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    chk_out("pre_new_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b0001;
    step();
    chk_out("pre_rel1", 4'b0000, 2'd1, 1'b0, 1'b0);
    step();
    chk_out("pre_regain0", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step();
    step();
    chk("pre_idle", 32'(dbg_state), 32'(S_IDLE));

    // 5. lone holder saturates, then release and new request on one edge
    bus.req = 4'b1000;
    step();
    chk_out("lone_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("lone.gnt", 32'(bus.gnt), 32'(4'b1000));
      chk("lone.timeout", 32'(bus.timeout), 32'(0));
    end
    bus.req = 4'b0001;
    step();
    chk_out("lone_rel", 4'b0000, 2'd3, 1'b0, 1'b0);
    step();
    chk_out("lone_next", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step();
    step();
    chk("lone_idle", 32'(dbg_state), 32'(S_IDLE));

    // 6. asynchronous reset in the middle of a grant (ptr is 0 here)
    bus.req = 4'b0010;
    step();
    chk_out("async_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk_out("async_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("async_mid.state", 32'(dbg_state), 32'(S_IDLE));
    step();
    bus.req = 4'b0110;
    resetn  = 1'b1;
    step();
    chk_out("async_after", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_timeout.md
Name: rr_arbiter_timeout

Overview:
Round-robin arbiter sharing one resource among N requesters, using hold-until-release grants. A grant is preempted when its holder exceeds a tenure limit while another requester waits. The block replaces fixed-priority grant FSMs wherever starvation is unacceptable, and sits between requester agents and the shared resource's select/enable logic.

Parameters:
N, 4, number of requesters (N >= 2)
MAX_HOLD, 16, cycles a grant may be held before it becomes preemptible (MAX_HOLD >= 1)

Ports:
clk  input  1  clock; all state changes on rising edge
resetn  input  1  asynchronous active-low reset
req  input  N  request per requester; level-sensitive, held high while resource is needed
gnt  output  N  registered one-hot grant; all-zero when nobody owns the resource
gnt_id  output  $clog2(N)  binary index of current owner; valid only while gnt != 0, otherwise holds last owner
busy  output  1  registered; high exactly when gnt != 0
timeout  output  1  registered one-cycle pulse when an owner is preempted by the tenure limit

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold_cnt=0, ptr=N-1, so requester 0 has highest priority after reset. Reset mid-grant drops gnt immediately, without waiting for clk.
- Internal: ptr is the last winner; hold_cnt is $clog2(MAX_HOLD+1) bits wide.
- Arbitration: winner = first i with req[i]=1, searching ptr+1, ptr+2, ... modulo N. Combinational on the current req; result is registered.
- States: IDLE, GRANT, GAP.
- IDLE: if any req at an edge -> gnt<=onehot(winner), gnt_id<=winner, ptr<=winner, hold_cnt<=1, busy<=1, state GRANT. Otherwise stay. Latency from req sampled to gnt visible is 1 cycle.
- GRANT, in priority order at each edge:
  1. req[gnt_id]=0 (release) -> gnt<=0, busy<=0, state GAP, no timeout pulse.
  2. hold_cnt==MAX_HOLD and any other req bit high (preempt) -> gnt<=0, busy<=0, timeout<=1 for one cycle, state GAP.
  3. Otherwise stay in GRANT; hold_cnt<=min(hold_cnt+1, MAX_HOLD) (saturating, never wraps).
- Release takes precedence over preempt on the same edge.
- A lone requester is never preempted. It holds indefinitely and hold_cnt saturates; preemption fires on the first edge another requester appears.
- GAP: gnt is low for exactly this one cycle (bus turnaround). At the next edge, if any req, arbitrate and grant as in IDLE (state GRANT). Otherwise go to IDLE.
- Minimum spacing between consecutive grants is 1 idle cycle.
- A preempted owner that keeps req high re-competes normally. With ptr at its index it ranks last.
- A requester whose req drops in the same cycle its grant is registered is released on the following edge (grant lasts 1 cycle).
- timeout is 0 in every cycle except the one following a preempt edge.
- No combinational path from req to any output.

Test Plan:
(N=4, MAX_HOLD=4)
- Reset: hold resetn low, toggle req=1111 -> gnt=0000, busy=0, timeout=0, gnt_id=0 throughout. Release resetn with req=1111 -> gnt=0001 one edge later.
- Single request: req=0100 from idle -> gnt=0100, gnt_id=2 after 1 edge. Drop req after 3 cycles -> gnt=0000 next edge, state returns to IDLE, no timeout.
- Fairness: req=1111 continuously, each owner drops its req 2 cycles after its grant and reasserts 1 cycle later -> grant order 0,1,2,3,0,... with exactly one gnt=0000 cycle between grants.
- Preempt: req=0001 held, req[1] raised 2 cycles after gnt=0001 -> gnt=0001 for exactly 4 cycles, timeout=1 for one cycle coincident with the gnt=0000 gap, then gnt=0010. Keep req[0] high -> req0 regains the grant only after req1 releases or is preempted.
- Lone holder plus simultaneous events: req=1000 held for 20 cycles -> gnt=1000 continuous, timeout never asserts. Then drop req[3] on the same edge req[0] rises with hold_cnt saturated -> release path taken (no timeout), gap, gnt=0001.
- Async reset mid-grant: assert resetn low between edges while gnt=0010 -> gnt=0000, busy=0 before the next edge. After release with req=0110 -> gnt=0010 (ptr reset to 3, search starts at 0).
